// File: rtl/traceback_window.sv
// Sliding-window Viterbi traceback with survivor store and oldest-first output.
// Ports:
//   clk, rst_n (async, active-low)
//   surv_valid/surv_ready, surv_row[S], best_state[M], surv_last : ACS rows in
//   out_valid/out_ready, out_bit, out_last : decoded bit stream out
//   busy : traceback or emit in progress
module traceback_window #(
  parameter int M = 2,
  parameter int L = 6,
  parameter int B = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              surv_valid,
  output logic              surv_ready,
  input  logic [(1<<M)-1:0] surv_row,
  input  logic [M-1:0]      best_state,
  input  logic              surv_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic              busy
);

  localparam int S      = 1 << M;
  localparam int D      = L + B;
  localparam int TIME_W = $clog2(D);
  localparam int CNT_W  = $clog2(D + 1);

  localparam logic [TIME_W-1:0] T_MAX   = TIME_W'(D - 1);
  localparam logic [TIME_W-1:0] T_ONE   = TIME_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  D_C     = CNT_W'(D);
  localparam logic [CNT_W-1:0]  L_C     = CNT_W'(L);
  localparam logic [CNT_W-1:0]  B_C     = CNT_W'(B);

  typedef enum logic [1:0] {
    IDLE,
    TRACE,
    DECODE,
    EMIT
  } state_e;

  state_e             state_q, state_d;
  logic [TIME_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic [M-1:0]       start_q, start_d;
  logic [M-1:0]       cur_q, cur_d;
  logic [TIME_W-1:0]  t_q, t_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flush_q, flush_d;
  logic               last_pend_q, last_pend_d;
  logic [CNT_W-1:0]   lifo_cnt_q, lifo_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               out_bit_q, out_bit_d;
  logic               out_last_q, out_last_d;

  logic [S-1:0]       mem_q [D];
  logic [D-1:0]       lifo_q;

  logic               accept;
  logic               push;
  logic               launch;
  logic               surv_bit;
  logic [M-1:0]       pred;
  logic [TIME_W-1:0]  t_dec;
  logic [TIME_W-1:0]  wr_inc;
  logic [TIME_W-1:0]  newest;
  logic [CNT_W-1:0]   pop_c;

  assign surv_ready = (state_q == IDLE) ||
                      ((state_q == EMIT) && (pend_q < D_C) &&
                       !flush_q && !last_pend_q);
  assign accept     = surv_valid && surv_ready;
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign out_last   = out_last_q;

  assign surv_bit = mem_q[t_q][cur_q];
  assign pred     = {cur_q[M-2:0], surv_bit};
  assign t_dec    = (t_q == '0) ? T_MAX : t_q - T_ONE;
  assign wr_inc   = (wr_ptr_q == T_MAX) ? '0 : wr_ptr_q + T_ONE;
  assign pop_c    = lifo_cnt_q - CNT_ONE;

  // Row index of the most recent survivor, including one written this cycle.
  assign newest = accept ? wr_ptr_q :
                  ((wr_ptr_q == '0) ? T_MAX : wr_ptr_q - T_ONE);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pend_d      = pend_q;
    start_d     = start_q;
    cur_d       = cur_q;
    t_d         = t_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    last_pend_d = last_pend_q;
    lifo_cnt_d  = lifo_cnt_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_last_d  = out_last_q;
    push        = 1'b0;
    launch      = 1'b0;

    if (accept) begin
      wr_ptr_d = wr_inc;
      pend_d   = pend_q + CNT_ONE;
      start_d  = best_state;
      if (surv_last) begin
        last_pend_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        launch = 1'b1;
      end
      TRACE: begin
        cur_d = pred;
        t_d   = t_dec;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DECODE;
          cnt_d   = B_C;
        end
      end
      DECODE: begin
        cur_d      = pred;
        t_d        = t_dec;
        cnt_d      = cnt_q - CNT_ONE;
        push       = 1'b1;
        lifo_cnt_d = lifo_cnt_q + CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = EMIT;
          if (flush_q) begin
            pend_d   = '0;
            wr_ptr_d = '0;
            start_d  = '0;
          end else begin
            pend_d = pend_q - B_C;
          end
        end
      end
      EMIT: begin
        // Output register refills from the LIFO top on each handshake.
        if (!out_valid_q || out_ready) begin
          if (lifo_cnt_q != '0) begin
            out_valid_d = 1'b1;
            out_bit_d   = lifo_q[pop_c[TIME_W-1:0]];
            out_last_d  = flush_q && (lifo_cnt_q == CNT_ONE);
            lifo_cnt_d  = pop_c;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            flush_d     = 1'b0;
            state_d     = IDLE;
            launch      = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush takes priority over a full window; both trace from the newest row.
    if (launch) begin
      if (last_pend_d) begin
        state_d     = DECODE;
        flush_d     = 1'b1;
        last_pend_d = 1'b0;
        cnt_d       = pend_d;
        cur_d       = '0;
        t_d         = newest;
      end else if (pend_d == D_C) begin
        state_d = TRACE;
        cnt_d   = L_C;
        cur_d   = start_d;
        t_d     = newest;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      pend_q      <= '0;
      start_q     <= '0;
      cur_q       <= '0;
      t_q         <= '0;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      last_pend_q <= 1'b0;
      lifo_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pend_q      <= pend_d;
      start_q     <= start_d;
      cur_q       <= cur_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      last_pend_q <= last_pend_d;
      lifo_cnt_q  <= lifo_cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
    end
  end

  // Storage arrays carry no reset; pointers qualify their contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= surv_row;
    end
    if (push) begin
      lifo_q[lifo_cnt_q[TIME_W-1:0]] <= cur_q[M-1];
    end
  end

endmodule

// File: doc/traceback_window.md
# traceback_window

Sliding-window Viterbi traceback unit with internal survivor memory, configurable decision depth and block size, and in-order output. It sits between the add-compare-select array and the decoded-bit sink. It accepts one survivor row per symbol and performs L-step "discard" traceback followed by a B-step decode traceback from the per-step best state. It emits decoded bits oldest-first over a valid/ready stream, with tail-terminated flush on frame end.

## Interface
- M, default 2: encoder memory order; S = 2^M states.
- L, default 6: decision depth in discarded traceback steps; L >= 1.
- B, default 4: bits decoded per traceback pass; B >= 1.
- D (localparam) = L + B: survivor rows stored; TIME_W = $clog2(D).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- surv_valid  in  1  survivor row present.
- surv_ready  out  1  row accepted on surv_valid && surv_ready.
- surv_row  in  S  bit s = survivor (predecessor LSB) for state s.
- best_state  in  M  lowest-metric state after this row.
- surv_last  in  1  row is final (tail-terminated) symbol of the frame.
- out_valid  out  1  decoded bit present.
- out_ready  in  1  sink accepts on out_valid && out_ready.
- out_bit  out  1  decoded bit, oldest first.
- out_last  out  1  final bit of frame; qualified by out_valid.
- busy  out  1  FSM not IDLE.

## Operation
- Memory: D x S register array, combinational read. Accepted row is written at wr_ptr. wr_ptr increments and wraps D-1 -> 0. best_state is latched as start_state. Undecoded count `pend` increments (max D).
- Trellis: state s at time t has predecessor {s[M-2:0], mem[t][s]}. The decoded bit for time t is s[M-1].
- FSM: IDLE, TRACE, DECODE, EMIT.
- IDLE -> TRACE when an accepted row makes pend == D and surv_last = 0. Trace starts at row wr_ptr-1 from start_state, using L steps in TRACE, then B steps in DECODE.
- IDLE -> DECODE (flush) on accepted row with surv_last = 1, regardless of pend. Start state is 0, forced by tail termination. pend steps are decoded, with no discard.
- Each step takes one cycle: update state to predecessor, decrement the time index with wrap 0 -> D-1.
- DECODE pushes each bit into a D-deep LIFO. pend -= decoded count at DECODE exit. DECODE -> EMIT.
- EMIT pops the LIFO on each handshake, so output is forward (oldest-first) order.
- EMIT -> IDLE when the LIFO empties. After a flush, out_last = 1 on the last popped bit, and wr_ptr, pend and start_state clear for the next frame.
- surv_ready = 1 in IDLE. surv_ready = 1 in EMIT only when pend < D and no flush is in progress. Otherwise surv_ready = 0.
- A row accepted in EMIT that fills pend to D, or carries surv_last, arms a pending trigger. That trigger is taken on the EMIT -> IDLE edge, going straight to TRACE/DECODE.
- surv_last arriving with pend reaching D: flush wins and decodes all D bits.
- A frame shorter than D rows is decoded entirely by flush.

## Timing
- Reset (async assert): FSM IDLE; wr_ptr, pend, LIFO pointer and start_state = 0; out_valid = 0, out_bit = 0, out_last = 0, busy = 0; surv_ready = 1 after release.
- The memory array is not reset.
- Normal pass: trigger row accepted at edge n. TRACE covers cycles n+1..n+L. DECODE covers n+L+1..n+L+B. out_valid is first high after edge n+L+B+1.
- Flush pass: first out_valid follows pend+1 edges after the trigger.
- EMIT delivers at most 1 bit per cycle. out_bit and out_last are held stable while out_valid && !out_ready.
- busy is high from the edge after the trigger until the edge that empties the LIFO.

## Test plan
- M=2, L=6, B=4. Input bits i%3==1 for 48 bits plus 2 zero tail bits, encoded with next = {bit, s>>1}. True-path survivor bits are correct; off-path bits are all ones; best_state = true state. Required: 50 out bits equal to the input in order, out_last on bit 50 only.
- Latency: 10th row accepted at edge n (first trigger). Required: out_valid low through edge n+10, high after edge n+11, and out_bit = input bit 0.
- Backpressure: hold out_ready = 0 for 7 cycles mid-EMIT. Required: out_bit/out_valid frozen; surv_ready drops once pend = 10; no bit lost or duplicated over the full frame.
- Short frame: 3 rows (bits 1,0,0) with surv_last on row 3. Required: out = 1,0,0 in order, out_last with the third bit, then busy = 0 and wr_ptr = 0.
- Wrap: 25-row frame spanning two wr_ptr wraps. Required: all 25 bits correct in order.
- Reset during EMIT: drop rst_n between edges. Required: out_valid = 0 and busy = 0 immediately without a clock. After release, surv_ready = 1 and the next 3-row frame decodes correctly.
